// File: rtl/deco_pkg.sv
// Shared types for the decode-and-dispatch front end: opcodes, queues, functional
// units, the instruction view and the buffered dispatch entry.
package deco_pkg;

  localparam int DECO_XLEN      = 64;
  localparam int DISPATCH_DEPTH = 4;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_LOAD_FP  = 7'b0000111,
    OP_FENCE    = 7'b0001111,
    OP_ALU_I    = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_ALU_I_W  = 7'b0011011,
    OP_STORE    = 7'b0100011,
    OP_STORE_FP = 7'b0100111,
    OP_ATOMICS  = 7'b0101111,
    OP_ALU      = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_ALU_W    = 7'b0111011,
    OP_FMADD    = 7'b1000011,
    OP_FMSUB    = 7'b1000111,
    OP_FNMSUB   = 7'b1001011,
    OP_FNMADD   = 7'b1001111,
    OP_FP       = 7'b1010011,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_et;

  typedef enum logic [0:0] {
    INTEGER_QUEUE = 1'b0,
    MEMORY_QUEUE  = 1'b1
  } queue_et;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_DIV    = 3'd3,
    UNIT_MEM    = 3'd4
  } functional_unit_et;

  typedef enum logic [1:0] {
    RV32I = 2'd0,
    RV32E = 2'd1,
    RV64I = 2'd2
  } base_integer_set_et;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } common_format_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } itype_format_t;

  typedef union packed {
    common_format_t common;
    itype_format_t  itype;
  } instruction_t;

  // pc is held at full width; narrower cores zero-extend into it
  typedef struct packed {
    logic [DECO_XLEN-1:0] pc;
    instruction_t         inst;
    functional_unit_et    unit;
    logic                 illegal;
  } dispatch_entry_t;

  typedef struct packed {
    queue_et           queue;
    functional_unit_et unit;
    logic              illegal;
  } decode_t;

endpackage

// File: rtl/deco_fifo.sv
// In-order circular FIFO of dispatch entries with registered valid/full flags
// and a synchronous flush that wins over any same-cycle push or pop.
module deco_fifo
  import deco_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  dispatch_entry_t         entry_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    full_o,
  output dispatch_entry_t         entry_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

  dispatch_entry_t mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            valid_r;
  logic            full_r;
  logic            push_s;
  logic            pop_s;

  assign push_s = push_i & ~full_r;
  assign pop_s  = valid_r & ready_i;

  // next occupancy; flush discards everything including in-flight push/pop
  always_comb begin
    count_next_s = count_r;
    if (flush_i) begin
      count_next_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // pointers, count and the flags derived from the next count
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CW{1'b0}});
      full_r  <= (count_next_s == CNT_FULL);
    end
  end

  // entry storage carries no reset; contents are qualified by valid
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      mem_r[wr_ptr_r] <= entry_i;
    end
  end

  assign entry_o = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign valid_o = valid_r;
  assign full_o  = full_r;

endmodule

// File: rtl/deco_dispatch_buffer.sv
// Decodes one fetched instruction per cycle into a target queue and functional
// unit, then buffers it in the integer or memory dispatch FIFO.
module deco_dispatch_buffer
  import deco_pkg::*;
#(
  parameter int                 XLEN     = DECO_XLEN,
  parameter int                 DEPTH    = DISPATCH_DEPTH,
  parameter base_integer_set_et BASE_ISA = RV64I,
  parameter bit                 EXT_M    = 1'b1,
  parameter bit                 EXT_A    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    inst_valid_i,
  input  instruction_t            inst_i,
  input  logic [XLEN-1:0]         pc_i,
  output logic                    inst_ready_o,
  output logic                    int_valid_o,
  input  logic                    int_ready_i,
  output dispatch_entry_t         int_entry_o,
  output logic [$clog2(DEPTH):0]  int_count_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output dispatch_entry_t         mem_entry_o,
  output logic [$clog2(DEPTH):0]  mem_count_o
);

  // Illegal encodings fall back to the integer queue as a plain ALU op so the
  // exception is raised in order by the integer pipeline.
  function automatic decode_t decode_inst(input instruction_t inst);
    decode_t d;
    d.queue   = INTEGER_QUEUE;
    d.unit    = UNIT_ALU;
    d.illegal = 1'b0;
    case (inst.common.opcode)
      OP_LUI, OP_AUIPC, OP_ALU_I, OP_FENCE, OP_SYSTEM: d.unit = UNIT_ALU;
      OP_BRANCH, OP_JAL, OP_JALR:                      d.unit = UNIT_BRANCH;
      OP_ALU_I_W:                                      d.illegal = (BASE_ISA != RV64I);
      OP_ALU, OP_ALU_W: begin
        if (inst.common.func7 == 7'b0000001) begin
          d.unit    = inst.common.func3[2] ? UNIT_DIV : UNIT_MUL;
          d.illegal = !EXT_M;
        end else begin
          d.unit    = UNIT_ALU;
        end
        d.illegal = d.illegal |
                    ((inst.common.opcode == OP_ALU_W) && (BASE_ISA != RV64I));
      end
      OP_LOAD, OP_STORE: begin
        d.queue = MEMORY_QUEUE;
        d.unit  = UNIT_MEM;
      end
      OP_ATOMICS: begin
        d.queue   = MEMORY_QUEUE;
        d.unit    = UNIT_MEM;
        d.illegal = !EXT_A;
      end
      default: d.illegal = 1'b1;
    endcase
    d.queue = d.illegal ? INTEGER_QUEUE : d.queue;
    d.unit  = d.illegal ? UNIT_ALU      : d.unit;
    return d;
  endfunction

  decode_t         dec_s;
  dispatch_entry_t entry_s;
  logic            accept_s;
  logic            int_push_s;
  logic            mem_push_s;
  logic            int_full_s;
  logic            mem_full_s;

  // classify the offered instruction and assemble its entry
  always_comb begin
    dec_s           = decode_inst(inst_i);
    entry_s.pc      = DECO_XLEN'(pc_i);
    entry_s.inst    = inst_i;
    entry_s.unit    = dec_s.unit;
    entry_s.illegal = dec_s.illegal;
  end

  // ready depends only on registered fullness, never on the offered data
  assign inst_ready_o = ~int_full_s & ~mem_full_s & rstn_i;
  assign accept_s     = inst_valid_i & inst_ready_o;
  assign int_push_s   = accept_s & (dec_s.queue == INTEGER_QUEUE);
  assign mem_push_s   = accept_s & (dec_s.queue == MEMORY_QUEUE);

  deco_fifo #(.DEPTH(DEPTH)) u_int_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (int_push_s),
    .entry_i (entry_s),
    .ready_i (int_ready_i),
    .valid_o (int_valid_o),
    .full_o  (int_full_s),
    .entry_o (int_entry_o),
    .count_o (int_count_o)
  );

  deco_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (mem_push_s),
    .entry_i (entry_s),
    .ready_i (mem_ready_i),
    .valid_o (mem_valid_o),
    .full_o  (mem_full_s),
    .entry_o (mem_entry_o),
    .count_o (mem_count_o)
  );

endmodule

// File: tb/tb_deco_dispatch_buffer.sv
// Directed bench for deco_dispatch_buffer: a default RV64IM instance and a
// narrow RV32I/no-M/with-A instance driven by the same stimulus.
module tb_deco_dispatch_buffer;
  import deco_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LD   = 32'h00813283;
  localparam logic [31:0] I_ADDW = 32'h003100BB;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_FLW  = 32'h00012007;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_AMO  = 32'h0020A02F;

  logic        clk = 1'b0;
  logic        rstn, flush, inst_valid, int_ready, mem_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic            rdy_a, iv_a, mv_a, rdy_b, iv_b, mv_b;
  dispatch_entry_t ie_a, me_a, ie_b, me_b;
  logic [2:0]      ic_a, mc_a, ic_b, mc_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  deco_dispatch_buffer dut_a (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .inst_valid_i(inst_valid),
    .inst_i(inst), .pc_i(pc), .inst_ready_o(rdy_a),
    .int_valid_o(iv_a), .int_ready_i(int_ready), .int_entry_o(ie_a), .int_count_o(ic_a),
    .mem_valid_o(mv_a), .mem_ready_i(mem_ready), .mem_entry_o(me_a), .mem_count_o(mc_a)
  );

  deco_dispatch_buffer #(.XLEN(32), .BASE_ISA(RV32I), .EXT_M(1'b0), .EXT_A(1'b1)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .inst_valid_i(inst_valid),
    .inst_i(inst), .pc_i(pc[31:0]), .inst_ready_o(rdy_b),
    .int_valid_o(iv_b), .int_ready_i(int_ready), .int_entry_o(ie_b), .int_count_o(ic_b),
    .mem_valid_o(mv_b), .mem_ready_i(mem_ready), .mem_entry_o(me_b), .mem_count_o(mc_b)
  );

  function automatic dispatch_entry_t mk(input logic [63:0] p, input logic [31:0] i,
                                         input functional_unit_et u, input logic ill);
    dispatch_entry_t e;
    e.pc      = p;
    e.inst    = i;
    e.unit    = u;
    e.illegal = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction for one edge, then idle one edge so it drains
  task automatic push1(input logic [31:0] i, input logic [63:0] p);
    inst_valid = 1'b1;
    inst       = i;
    pc         = p;
    cyc();
    inst_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; inst_valid = 1'b0; int_ready = 1'b1; mem_ready = 1'b1;
    inst = 32'h0; pc = 64'h0;
    cyc(); cyc();
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_int_valid", iv_a, 1'b0);
    chk("rst_mem_valid", mv_a, 1'b0);
    chk("rst_counts", {ic_a, mc_a}, 6'd0);
    #2 rstn = 1'b1;
    #1 chk("ready_after_release", rdy_a, 1'b1);
    cyc();

    push1(I_ADD, 64'h1000);
    chk("add_valid", iv_a, 1'b1);
    chk("add_entry", ie_a, mk(64'h1000, I_ADD, UNIT_ALU, 1'b0));
    chk("add_mem_empty", mv_a, 1'b0);
    chk("add_entry_b", ie_b, mk(64'h1000, I_ADD, UNIT_ALU, 1'b0));
    cyc();
    chk("add_popped", {iv_a, ic_a}, 4'd0);

    push1(I_LD, 64'h1004);
    chk("ld_mem_valid", mv_a, 1'b1);
    chk("ld_int_empty", iv_a, 1'b0);
    chk("ld_entry", me_a, mk(64'h1004, I_LD, UNIT_MEM, 1'b0));
    chk("ld_entry_b", me_b, mk(64'h1004, I_LD, UNIT_MEM, 1'b0));
    cyc();

    push1(I_ADDW, 64'h1008);
    chk("addw_rv64", ie_a, mk(64'h1008, I_ADDW, UNIT_ALU, 1'b0));
    chk("addw_rv32_illegal", ie_b, mk(64'h1008, I_ADDW, UNIT_ALU, 1'b1));
    chk("addw_rv32_int_valid", iv_b, 1'b1);
    cyc();

    push1(I_MUL, 64'h100C);
    chk("mul_unit", ie_a, mk(64'h100C, I_MUL, UNIT_MUL, 1'b0));
    chk("mul_no_m", ie_b, mk(64'h100C, I_MUL, UNIT_ALU, 1'b1));
    cyc();

    push1(I_DIV, 64'h1010);
    chk("div_unit", ie_a, mk(64'h1010, I_DIV, UNIT_DIV, 1'b0));
    chk("div_no_m", ie_b, mk(64'h1010, I_DIV, UNIT_ALU, 1'b1));
    cyc();

    push1(I_FLW, 64'h1014);
    chk("flw_illegal", ie_a, mk(64'h1014, I_FLW, UNIT_ALU, 1'b1));
    chk("flw_illegal_b", ie_b, mk(64'h1014, I_FLW, UNIT_ALU, 1'b1));
    chk("flw_not_mem", mv_a, 1'b0);
    cyc();

    push1(I_JAL, 64'h1018);
    chk("jal_branch", ie_a, mk(64'h1018, I_JAL, UNIT_BRANCH, 1'b0));
    cyc();

    push1(I_AMO, 64'h101C);
    chk("amo_no_a", {iv_a, mv_a}, 2'b10);
    chk("amo_no_a_entry", ie_a, mk(64'h101C, I_AMO, UNIT_ALU, 1'b1));
    chk("amo_with_a", {iv_b, mv_b}, 2'b01);
    chk("amo_with_a_entry", me_b, mk(64'h101C, I_AMO, UNIT_MEM, 1'b0));
    cyc();

    // fill the memory queue, then stream through it with push and pop together
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", rdy_a, 1'b1);
      inst_valid = 1'b1; inst = I_LD; pc = 64'h2000 + 64'(4 * i);
      cyc();
    end
    pc = 64'h2010;
    chk("full_count", mc_a, 3'd4);
    chk("full_ready", rdy_a, 1'b0);
    chk("full_ready_b", rdy_b, 1'b0);
    chk("full_head", me_a.pc, 64'h2000);
    cyc();
    chk("full_hold", mc_a, 3'd4);
    mem_ready = 1'b1;
    cyc();
    chk("first_pop_count", mc_a, 3'd3);
    chk("first_pop_head", me_a.pc, 64'h2004);
    chk("first_pop_ready", rdy_a, 1'b1);
    for (int k = 0; k < 12; k++) begin
      pc = 64'h2010 + 64'(4 * k);
      cyc();
      chk("stream_count", mc_a, 3'd3);
      chk("stream_head", me_a.pc, 64'h2008 + 64'(4 * k));
    end
    inst_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("drain_count", mc_a, 3'(2 - j));
      if (j < 2) chk("drain_head", me_a.pc, 64'h2038 + 64'(4 * j));
    end
    chk("drain_empty", mv_a, 1'b0);

    // flush with three entries queued and a push plus pop in flight
    int_ready = 1'b0; mem_ready = 1'b0;
    inst_valid = 1'b1;
    inst = I_ADD; pc = 64'h3000; cyc();
    inst = I_LD;  pc = 64'h3004; cyc();
    inst = I_ADD; pc = 64'h3008; cyc();
    chk("preflush_counts", {ic_a, mc_a}, {3'd2, 3'd1});
    inst = I_LD; pc = 64'h300C; mem_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; inst_valid = 1'b0;
    chk("flush_counts", {ic_a, mc_a, ic_b, mc_b}, 12'd0);
    chk("flush_valids", {iv_a, mv_a}, 2'b00);
    cyc();
    chk("flushed_push_gone", {mv_a, mc_a}, 4'd0);
    push1(I_ADD, 64'h3010);
    chk("post_flush_entry", ie_a, mk(64'h3010, I_ADD, UNIT_ALU, 1'b0));
    chk("post_flush_count", ic_a, 3'd1);

    // asynchronous reset mid-burst
    inst_valid = 1'b1; inst = I_LD; pc = 64'h4000; cyc();
    pc = 64'h4004;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_counts", {ic_a, mc_a}, 6'd0);
    chk("async_rst_valids", {iv_a, mv_a}, 2'b00);
    chk("async_rst_ready", rdy_a, 1'b0);
    inst_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    chk("rerelease_ready", rdy_a, 1'b1);
    inst_valid = 1'b1; inst = I_ADD; pc = 64'h5000;
    cyc();
    inst_valid = 1'b0;
    chk("after_reset_add", ie_a, mk(64'h5000, I_ADD, UNIT_ALU, 1'b0));
    chk("after_reset_count", {ic_a, mc_a}, {3'd1, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/deco_dispatch_buffer.md
# deco_dispatch_buffer

Parametrised decode-and-dispatch buffer between instruction fetch and the issue queues. It takes one 32-bit instruction per cycle over a valid/ready handshake and classifies it by opcode into a target queue (`INTEGER_QUEUE` / `MEMORY_QUEUE`) and a functional unit. It flags encodings illegal for the configured ISA, and buffers the result in one in-order FIFO per queue, each with its own valid/ready output. It generalises the single-instruction combinational decoder with configurable base ISA, optional M/A extensions, buffering depth and flush.

## Interface
- `XLEN`, 64: PC width.
- `DEPTH`, 4: entries per queue FIFO; power of two, ≥2.
- `BASE_ISA`, `RV64I`: `base_integer_set_et`; `RV32I`/`RV32E` make W-opcodes illegal.
- `EXT_M`, 1: enables MUL/DIV decode.
- `EXT_A`, 0: enables `OP_ATOMICS` decode.
- `clk_i`  in  1  clock; all state on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush of both FIFOs.
- `inst_valid_i`  in  1  instruction offered.
- `inst_i`  in  32  `instruction_t`.
- `pc_i`  in  `XLEN`  PC of `inst_i`.
- `inst_ready_o`  out  1  instruction accepted when `valid & ready`.
- `int_valid_o` / `mem_valid_o`  out  1  queue head valid.
- `int_ready_i` / `mem_ready_i`  in  1  consumer pops head when `valid & ready`.
- `int_entry_o` / `mem_entry_o`  out  `$bits(dispatch_entry_t)`  head entry.
- `int_count_o` / `mem_count_o`  out  `$clog2(DEPTH)+1`  occupancy.

## Operation
- Decode is combinational on `inst_i.common.opcode`, `func3` and `func7`:
  - `LUI`, `AUIPC`, `ALU`, `ALU_I`, `FENCE`, `SYSTEM` → integer queue, `UNIT_ALU`.
  - `BRANCH`, `JAL`, `JALR` → integer queue, `UNIT_BRANCH`.
  - `OP_ALU`/`OP_ALU_W` with `func7=0000001` → `UNIT_MUL` if `func3[2]=0`, else `UNIT_DIV`; illegal when `EXT_M=0`.
  - `ALU_I_W`/`ALU_W` are illegal unless `BASE_ISA=RV64I`.
  - `LOAD`, `STORE`, and `ATOMICS` (legal only if `EXT_A=1`) → memory queue, `UNIT_MEM`.
  - All FP opcodes and unknown opcodes are illegal.
- An illegal instruction is routed to the integer queue as `UNIT_ALU` with `illegal=1`. It is never dropped.
- Entry captured: `{pc, inst, unit, illegal}`.
- `inst_ready_o = !int_full & !mem_full & rstn_i`. It is independent of `inst_i`, so there is no data-to-ready path.
- Each FIFO has a circular buffer with `$clog2(DEPTH)`-bit rd/wr pointers that wrap naturally, plus a count register.
- Push and pop on the same queue in the same cycle: both happen and the count is unchanged. This is legal at count=0 only if the push lands a cycle earlier. At count=0 a pop is impossible because valid=0.
- `flush_i` zeroes pointers and counts in both FIFOs. It takes priority over a same-cycle push and pop: the accepted instruction is discarded, and the handshake still counts as completed.
- The order of entries within a queue matches the acceptance order. There is no ordering guarantee across queues.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - all pointers and counts = 0;
  - `int_valid_o = mem_valid_o = 0`;
  - `inst_ready_o = 0` while `rstn_i` is low, and 1 in the first cycle after release.
  - Entry outputs are don't-care when valid=0.
- Latency: an instruction accepted at edge N is visible at its queue head after edge N, with valid=1 in cycle N+1. Minimum pass-through is 1 cycle.
- `valid_o = (count != 0)`, driven from registered state only. The head entry is stable while `valid & !ready`.
- Full (count = `DEPTH`) on either queue deasserts `inst_ready_o` in the same cycle as that count appears. Pops on that cycle free space for the next cycle only.
- Reset asserted mid-operation clears all contents immediately. No pop handshake completes in that cycle.

## Structure
- Add to `deco_pkg`:
  - `dispatch_entry_t` (packed: `logic [XLEN-1:0] pc`, `instruction_t inst`, `functional_unit_et unit`, `logic illegal`);
  - `DISPATCH_DEPTH` default constant.
- Reuse `opcode_et`, `queue_et`, `functional_unit_et` and `base_integer_set_et`.
- One sub-module, `deco_fifo`, parametrised on `DEPTH`, instantiated twice. The decode logic is a function local to `deco_dispatch_buffer`.

## Test plan
- `ADD x1,x2,x3` (`0x003100B3`), PC `0x1000` → `int_valid_o=1` next cycle; entry `unit=UNIT_ALU`, `illegal=0`, `pc=0x1000`.
- `LD x5,8(x2)` (`0x00813283`) → memory queue, `UNIT_MEM`. With `BASE_ISA=RV32I`, `ADDW` (`0x003100BB`) → integer queue, `illegal=1`.
- `MUL` (`0x023100B3`) → `UNIT_MUL`; `DIV` (`0x023140B3`) → `UNIT_DIV`. With `EXT_M=0`, both give `illegal=1`. `FLW` (`0x00012007`) always gives `illegal=1`.
- `DEPTH=4`, `mem_ready_i=0`, push 4 loads → `mem_count_o=4`, `inst_ready_o=0`. Raise `mem_ready_i` → loads pop in PC order. During this, push/pop in the same cycle holds the count steady, and the pointer wrap is exercised over ≥3 fills.
- `flush_i` pulsed with 3 entries queued and a push in flight → both counts 0 and valids 0 next cycle; the flushed push does not appear.
- `rstn_i` dropped asynchronously mid-burst → outputs go to reset values before the next edge. After release, ADD accepted → normal operation.
